// File: rtl/line_xfer_pkg.sv
// Shared definitions for the line transfer engine: FSM states, beat sizing and
// the read-return tag that travels through the latency pipe.
package line_xfer_pkg;

    localparam int LINE_WORDS = 8;
    localparam int BEAT_W     = 3;
    localparam int WORD_W     = 32;
    localparam int LINE_W     = LINE_WORDS * WORD_W;
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WB,
        ST_RD,
        ST_DRAIN,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic              valid;
        logic [BEAT_W-1:0] beat;
    } ret_tag_t;

endpackage

// File: rtl/line_xfer_rd_lat_pipe.sv
// Delay line that carries {valid, beat} alongside each mm read so the return
// data lands in the right word of the fill line RD_LAT cycles later.
module rd_lat_pipe
    import line_xfer_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic     clk,
    input  logic     reset,
    input  ret_tag_t tag_i,
    output ret_tag_t tag_o
);

    ret_tag_t stage_q [RD_LAT];

    // Clearing every stage drops in-flight returns when a transfer is aborted.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < RD_LAT; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[RD_LAT-1];

endmodule

// File: rtl/line_xfer.sv
// Line transfer engine: serialises a dirty victim into 8 mm writes and gathers
// 8 mm reads into a refill line; writeback always precedes the fill.
module line_xfer
    import line_xfer_pkg::*;
#(
    parameter int LINE_AW = 27,
    parameter int WORDS   = 8,
    parameter int RD_LAT  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wb,
    input  logic                 req_fill,
    input  logic [LINE_AW-1:0]   wb_addr,
    input  logic [LINE_AW-1:0]   fill_addr,
    input  logic [LINE_W-1:0]    wb_line,
    output logic [LINE_AW+2:0]   mm_addr,
    output logic                 mm_wr,
    output logic                 mm_rd,
    output logic [WORD_W-1:0]    mm_wdata,
    input  logic [WORD_W-1:0]    mm_rdata,
    output logic [LINE_W-1:0]    fill_line,
    output logic                 done
);

    if (WORDS != LINE_WORDS || RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_cfg
        $error("line_xfer: unsupported WORDS or RD_LAT");
    end

    state_e              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                fill_q;
    logic [LINE_AW-1:0]  wb_addr_q, fill_addr_q;
    logic [LINE_W-1:0]   wb_line_q;
    logic [LINE_W-1:0]   fill_line_q;
    logic                accept;
    ret_tag_t            issue_tag, ret_tag;

    assign accept = (state_q == ST_IDLE) && req_valid;

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // NOTE: the request payload has no reset; it is only read after an accept has loaded it.
    always_ff @(posedge clk) begin
        if (accept) begin
            fill_q      <= req_fill;
            wb_addr_q   <= wb_addr;
            fill_addr_q <= fill_addr;
            wb_line_q   <= wb_line;
        end
    end

    // NOTE: defaults at the top of the block keep it free of inferred latches.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        unique case (state_q)
            ST_IDLE: begin
                beat_d = '0;
                if (req_valid) begin
                    if (req_wb)        state_d = ST_WB;
                    else if (req_fill) state_d = ST_RD;
                    else               state_d = ST_DONE;
                end
            end
            ST_WB: begin
                beat_d = beat_q + 1'b1;
                if (beat_q == LAST_BEAT) state_d = fill_q ? ST_RD : ST_DONE;
            end
            ST_RD: begin
                beat_d = beat_q + 1'b1;
                if (beat_q == LAST_BEAT) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Returns arrive in issue order, so the last beat's return ends the fill.
                if (ret_tag.valid && ret_tag.beat == LAST_BEAT) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign req_ready = (state_q == ST_IDLE);
    assign mm_wr     = (state_q == ST_WB);
    assign mm_rd     = (state_q == ST_RD);
    assign done      = (state_q == ST_DONE);

    always_comb begin
        mm_addr  = '0;
        mm_wdata = '0;
        if (state_q == ST_WB) begin
            mm_addr  = {wb_addr_q, beat_q};
            mm_wdata = wb_line_q[{beat_q, 5'b0} +: WORD_W];
        end else if (state_q == ST_RD) begin
            mm_addr  = {fill_addr_q, beat_q};
        end
    end

    assign issue_tag.valid = mm_rd;
    assign issue_tag.beat  = beat_q;

    rd_lat_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_lat_pipe (
        .clk   (clk),
        .reset (reset),
        .tag_i (issue_tag),
        .tag_o (ret_tag)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            fill_line_q <= '0;
        end else if (ret_tag.valid) begin
            fill_line_q[{ret_tag.beat, 5'b0} +: WORD_W] <= mm_rdata;
        end
    end

    assign fill_line = fill_line_q;

endmodule

// File: tb/tb_line_xfer.sv
// Bench for line_xfer: three instances (RD_LAT 1..3) driven by directed and random
// requests, checked every cycle against a per-request timeline model and a memory model.
module tb_line_xfer;

    localparam int AW = 27;
    localparam int MW = AW + 3;

    typedef struct {
        bit            wr;
        bit            rd;
        bit            done;
        bit            ready;
        bit            chk_fl;
        logic [MW-1:0] addr;
        logic [31:0]   wdata;
        logic [255:0]  fl;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fails  = 0;

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [MW-1:0] a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'hC3A5_0F00;
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_inst
        localparam int L = gi + 1;

        logic          reset, req_valid, req_ready, req_wb, req_fill;
        logic          mm_wr, mm_rd, done;
        logic [AW-1:0] wb_addr, fill_addr;
        logic [255:0]  wb_line, fill_line;
        logic [MW-1:0] mm_addr;
        logic [31:0]   mm_wdata, mm_rdata;

        exp_t          tl [int];
        logic [31:0]   ref_mem  [logic [MW-1:0]];
        logic [31:0]   resp_mem [logic [MW-1:0]];
        logic [255:0]  model_fl = '0;
        int            idle_at  = 0;
        bit            chk_on   = 1'b0;
        bit            fin      = 1'b0;

        line_xfer #(
            .LINE_AW (AW),
            .WORDS   (8),
            .RD_LAT  (L)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .req_valid (req_valid),
            .req_ready (req_ready),
            .req_wb    (req_wb),
            .req_fill  (req_fill),
            .wb_addr   (wb_addr),
            .fill_addr (fill_addr),
            .wb_line   (wb_line),
            .mm_addr   (mm_addr),
            .mm_wr     (mm_wr),
            .mm_rd     (mm_rd),
            .mm_wdata  (mm_wdata),
            .mm_rdata  (mm_rdata),
            .fill_line (fill_line),
            .done      (done)
        );

        function automatic logic [31:0] ref_rd(input logic [MW-1:0] a);
            return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
        endfunction

        function automatic logic [31:0] resp_rd(input logic [MW-1:0] a);
            return resp_mem.exists(a) ? resp_mem[a] : init_word(a);
        endfunction

        // Expected per-cycle outputs of one request accepted in cycle n.
        task automatic schedule(input int n, input bit wb, input bit fill,
                                input logic [AW-1:0] wa, input logic [AW-1:0] fa,
                                input logic [255:0] line);
            exp_t         e;
            logic [255:0] gathered;
            int           t;
            t = n + 1;
            gathered = model_fl;
            if (wb) begin
                for (int k = 0; k < 8; k++) begin
                    e = '{default: '0};
                    e.wr    = 1'b1;
                    e.addr  = {wa, 3'(k)};
                    e.wdata = line[32*k +: 32];
                    ref_mem[e.addr] = e.wdata;
                    tl[t] = e;
                    t++;
                end
            end
            if (fill) begin
                for (int k = 0; k < 8; k++) begin
                    e = '{default: '0};
                    e.rd   = 1'b1;
                    e.addr = {fa, 3'(k)};
                    gathered[32*k +: 32] = ref_rd(e.addr);
                    tl[t] = e;
                    t++;
                end
                for (int k = 0; k < L; k++) begin
                    e = '{default: '0};
                    tl[t] = e;
                    t++;
                end
            end
            model_fl = gathered;
            e = '{default: '0};
            e.done   = 1'b1;
            e.chk_fl = 1'b1;
            e.fl     = model_fl;
            tl[t]    = e;
            idle_at  = t + 1;
        endtask

        task automatic model_reset(input int c);
            exp_t e;
            for (int k = c + 1; k < idle_at; k++) tl.delete(k);
            e = '{default: '0};
            e.ready  = 1'b1;
            e.chk_fl = 1'b1;
            e.fl     = '0;
            tl[c+1]  = e;
            model_fl = '0;
            idle_at  = c + 1;
        endtask

        task automatic wait_cyc(input int c);
            while (cyc < c) @(negedge clk);
        endtask

        // Presents a request and holds it until the engine is idle; returns the accept cycle.
        task automatic issue(input bit wb, input bit fill, input logic [AW-1:0] wa,
                             input logic [AW-1:0] fa, input logic [255:0] line, output int acc);
            @(negedge clk);
            req_valid = 1'b1;
            req_wb    = wb;
            req_fill  = fill;
            wb_addr   = wa;
            fill_addr = fa;
            wb_line   = line;
            while (cyc < idle_at) @(negedge clk);
            acc = cyc;
            schedule(acc, wb, fill, wa, fa, line);
        endtask

        task automatic quiet();
            @(negedge clk);
            req_valid = 1'b0;
            req_wb    = 1'($urandom);
            req_fill  = 1'($urandom);
            wb_addr   = AW'($urandom);
            fill_addr = AW'($urandom);
            for (int k = 0; k < 8; k++) wb_line[32*k +: 32] = $urandom;
        endtask

        function automatic string nm(input string s);
            return $sformatf("L%0d %s", L, s);
        endfunction

        // Main memory: reads answer exactly L cycles after the strobe, else garbage.
        initial begin : responder
            logic [MW-1:0] ha [5];
            bit            hv [5];
            for (int i = 0; i < 5; i++) begin
                ha[i] = '0;
                hv[i] = 1'b0;
            end
            mm_rdata = '0;
            forever begin
                @(negedge clk);
                if (mm_wr === 1'b1) resp_mem[mm_addr] = mm_wdata;
                for (int i = 4; i > 0; i--) begin
                    ha[i] = ha[i-1];
                    hv[i] = hv[i-1];
                end
                ha[0] = mm_addr;
                hv[0] = (mm_rd === 1'b1);
                mm_rdata = hv[L] ? resp_rd(ha[L]) : $urandom;
            end
        end

        initial begin : compare
            exp_t         e;
            bit           have;
            logic [255:0] last_fl;
            last_fl = '0;
            forever begin
                @(negedge clk);
                if (chk_on) begin
                    have = (tl.exists(cyc) != 0);
                    if (have) begin
                        e = tl[cyc];
                        tl.delete(cyc);
                    end else begin
                        e = '{default: '0};
                        e.ready = 1'b1;
                    end
                    check(nm($sformatf("cyc%0d mm_wr", cyc)), mm_wr, e.wr);
                    check(nm($sformatf("cyc%0d mm_rd", cyc)), mm_rd, e.rd);
                    check(nm($sformatf("cyc%0d done", cyc)), done, e.done);
                    check(nm($sformatf("cyc%0d req_ready", cyc)), req_ready, e.ready);
                    if (e.wr || e.rd) check(nm($sformatf("cyc%0d mm_addr", cyc)), mm_addr, e.addr);
                    if (e.wr) check(nm($sformatf("cyc%0d mm_wdata", cyc)), mm_wdata, e.wdata);
                    if (have && e.chk_fl) begin
                        check(nm($sformatf("cyc%0d fill_line", cyc)), fill_line, e.fl);
                        last_fl = e.fl;
                    end else if (!have) begin
                        check(nm($sformatf("cyc%0d idle fill_line", cyc)), fill_line, last_fl);
                    end
                end
            end
        end

        initial begin : drive
            int            n, n2;
            logic [255:0]  ln, ln2, exp_fl;
            logic [AW-1:0] a0, a1;
            bit            rwb, rfl;

            reset = 1'b1;
            req_valid = 1'b0;
            req_wb = 1'b0;
            req_fill = 1'b0;
            wb_addr = '0;
            fill_addr = '0;
            wb_line = '0;
            repeat (3) @(negedge clk);
            reset = 1'b0;
            @(negedge clk);
            check(nm("reset req_ready"), req_ready, 1'b1);
            check(nm("reset mm_wr"), mm_wr, 1'b0);
            check(nm("reset mm_rd"), mm_rd, 1'b0);
            check(nm("reset mm_addr"), mm_addr, '0);
            check(nm("reset mm_wdata"), mm_wdata, '0);
            check(nm("reset done"), done, 1'b0);
            check(nm("reset fill_line"), fill_line, '0);
            idle_at = cyc;
            chk_on  = 1'b1;

            // Writeback only: words k+1 to line 0x10.
            for (int k = 0; k < 8; k++) ln[32*k +: 32] = 32'(k + 1);
            issue(1'b1, 1'b0, 27'h10, 27'h0, ln, n);
            quiet();
            check(nm("t1 first mm_wr"), mm_wr, 1'b1);
            check(nm("t1 first addr"), mm_addr, 30'h80);
            check(nm("t1 first data"), mm_wdata, 32'h1);
            wait_cyc(n + 8);
            check(nm("t1 last addr"), mm_addr, 30'h87);
            check(nm("t1 last data"), mm_wdata, 32'h8);
            wait_cyc(n + 9);
            check(nm("t1 done"), done, 1'b1);
            wait_cyc(n + 10);
            check(nm("t1 ready after done"), req_ready, 1'b1);

            // Fill only from line 3 with preloaded words 0xA0+k.
            for (int k = 0; k < 8; k++) begin
                ref_mem[MW'(32'h18 + k)]  = 32'hA0 + 32'(k);
                resp_mem[MW'(32'h18 + k)] = 32'hA0 + 32'(k);
                exp_fl[32*k +: 32]        = 32'hA0 + 32'(k);
            end
            issue(1'b0, 1'b1, 27'h5, 27'h3, ln, n);
            quiet();
            check(nm("t2 first mm_rd"), mm_rd, 1'b1);
            check(nm("t2 first addr"), mm_addr, 30'h18);
            wait_cyc(n + 8);
            check(nm("t2 last addr"), mm_addr, 30'h1F);
            wait_cyc(n + 9 + L);
            check(nm("t2 done"), done, 1'b1);
            check(nm("t2 fill_line"), fill_line, exp_fl);

            // Writeback + fill back-to-back.
            for (int k = 0; k < 8; k++) ln[32*k +: 32] = $urandom;
            issue(1'b1, 1'b1, 27'h100, 27'h200, ln, n);
            quiet();
            wait_cyc(n + 8);
            check(nm("t3 last wr"), mm_wr, 1'b1);
            check(nm("t3 last wr addr"), mm_addr, {27'h100, 3'd7});
            wait_cyc(n + 9);
            check(nm("t3 first rd no gap"), mm_rd, 1'b1);
            check(nm("t3 no wr in rd"), mm_wr, 1'b0);
            check(nm("t3 first rd addr"), mm_addr, {27'h200, 3'd0});
            wait_cyc(n + 17 + L);
            check(nm("t3 done"), done, 1'b1);

            // Neither flag: immediate done.
            issue(1'b0, 1'b0, 27'h7, 27'h9, ln, n);
            quiet();
            check(nm("t4 done"), done, 1'b1);
            check(nm("t4 no wr"), mm_wr, 1'b0);
            check(nm("t4 no rd"), mm_rd, 1'b0);
            wait_cyc(n + 2);
            check(nm("t4 ready"), req_ready, 1'b1);

            // Reset during RD beat 4.
            issue(1'b0, 1'b1, 27'h30, 27'h55, ln, n);
            quiet();
            wait_cyc(n + 5);
            check(nm("t5 beat4 addr"), mm_addr, {27'h55, 3'd4});
            reset = 1'b1;
            model_reset(cyc);
            @(negedge clk);
            reset = 1'b0;
            check(nm("t5 rd dropped"), mm_rd, 1'b0);
            check(nm("t5 wr low"), mm_wr, 1'b0);
            check(nm("t5 fill cleared"), fill_line, '0);
            check(nm("t5 ready"), req_ready, 1'b1);
            repeat (L + 4) begin
                @(negedge clk);
                check(nm("t5 no done"), done, 1'b0);
            end
            issue(1'b0, 1'b1, 27'h31, 27'h56, ln, n);
            quiet();
            wait_cyc(n + 9 + L);
            check(nm("t5 refill done"), done, 1'b1);

            // Request held while busy: second one taken only once idle.
            for (int k = 0; k < 8; k++) ln2[32*k +: 32] = $urandom;
            issue(1'b1, 1'b1, 27'h40, 27'h41, ln, n);
            issue(1'b0, 1'b1, 27'h7FF, 27'h2A, ln2, n2);
            quiet();
            check(nm("t6 second rd"), mm_rd, 1'b1);
            check(nm("t6 second addr"), mm_addr, {27'h2A, 3'd0});
            wait_cyc(n2 + 9 + L);
            check(nm("t6 done"), done, 1'b1);

            // Random traffic over a small address pool so writebacks and fills collide.
            for (int it = 0; it < 40; it++) begin
                rwb = 1'($urandom);
                rfl = 1'($urandom);
                a0  = AW'(32'h1000 + $urandom_range(0, 3));
                a1  = AW'(32'h1000 + $urandom_range(0, 3));
                for (int k = 0; k < 8; k++) ln[32*k +: 32] = $urandom;
                issue(rwb, rfl, a0, a1, ln, n);
                if ($urandom_range(0, 2) != 0) begin
                    quiet();
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end
            end
            quiet();
            wait_cyc(idle_at + 2);
            fin = 1'b1;
        end
    end

    initial begin : finish_blk
        int t;
        t = 0;
        while (!(g_inst[0].fin && g_inst[1].fin && g_inst[2].fin) && t < 20000) begin
            @(posedge clk);
            t++;
        end
        check("all instances finished", {g_inst[0].fin, g_inst[1].fin, g_inst[2].fin}, 3'b111);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
